// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - generic pipeline stage register with valid/ready, 2-entry skid, freeze, flush
// and a saturating bubble counter.
module pipe_stage_skid_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    input  logic              bubble_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic accept;
    logic pop;

    // Ready comes only from registered state, so no combinational path runs from out_ready to in_ready.
    assign in_ready   = !rst && !skid_v_q && !freeze;
    assign out_valid  = main_v_q && !freeze;
    assign out_ctrl   = main_ctrl_q;
    assign out_data   = main_data_q;
    assign bubble_cnt = bubble_cnt_q;

    assign accept = in_valid && in_ready && !flush;
    assign pop    = out_valid && out_ready;

    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_ctrl_d = main_ctrl_q;
        skid_ctrl_d = skid_ctrl_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Control is zeroed so a squashed entry cannot have side effects; data is left as is.
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case ({main_v_q, skid_v_q})
                2'b00: begin
                    if (accept) begin
                        main_v_d    = 1'b1;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                2'b10: begin
                    if (accept && !pop) begin
                        skid_v_d    = 1'b1;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (pop && !accept) begin
                        main_v_d = 1'b0;
                    end else if (accept && pop) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                2'b11: begin
                    if (pop) begin
                        skid_v_d    = 1'b0;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_clr) begin
            bubble_cnt_d = '0;
        end else if (out_ready && !out_valid && bubble_cnt_q != CNT_MAX) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q     <= 1'b0;
            skid_v_q     <= 1'b0;
            main_ctrl_q  <= '0;
            skid_ctrl_q  <= '0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            main_v_q     <= main_v_d;
            skid_v_q     <= skid_v_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_ctrl_q  <= skid_ctrl_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - directed bench with occupancy model and ordered scoreboard
// for pipe_stage_skid_reg (CNT_W=4).
module tb_pipe_stage_skid_reg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              freeze;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  bubble_cnt;
    logic              bubble_clr;

    int checks = 0;
    int errors = 0;
    int exp_bub = 0;
    logic [CTRL_W+DATA_W-1:0] sb[$];

    pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .bubble_cnt(bubble_cnt), .bubble_clr(bubble_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the comb outputs mid-cycle, advances the model, then moves to just after the next edge.
    task automatic cycle();
        logic eir, eov, acc, pp;
        logic [CTRL_W+DATA_W-1:0] front;
        @(negedge clk);
        eir = !rst && sb.size() < 2 && !freeze;
        eov = sb.size() > 0 && !freeze;
        chk("in_ready", 64'(in_ready), 64'(eir));
        chk("out_valid", 64'(out_valid), 64'(eov));
        chk("bubble_cnt", 64'(bubble_cnt), 64'(exp_bub));
        if (sb.size() > 0) begin
            front = sb[0];
            chk("out_ctrl", 64'(out_ctrl), 64'(front[CTRL_W+DATA_W-1:DATA_W]));
            chk("out_data", out_data, front[DATA_W-1:0]);
        end
        acc = in_valid && eir && !flush;
        pp  = eov && out_ready;
        if (rst || bubble_clr) exp_bub = 0;
        else if (out_ready && !eov && exp_bub < CNT_MAX) exp_bub++;
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (pp) void'(sb.pop_front());
            if (acc) sb.push_back({in_ctrl, in_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    int bub_before;

    initial begin
        rst = 1'b1; flush = 1'b0; freeze = 1'b0; out_ready = 1'b0; bubble_clr = 1'b0;
        drive(1'b0, '0, '0);
        cycle();
        chk("rst_out_ctrl", 64'(out_ctrl), 64'h0);
        chk("rst_out_data", out_data, 64'h0);
        cycle();
        rst = 1'b0;

        // single entry, 1-cycle latency, then a bubble
        out_ready = 1'b1; bubble_clr = 1'b1;
        drive(1'b1, 8'h5A, 64'h1234);
        cycle();
        bubble_clr = 1'b0;
        drive(1'b0, '0, '0);
        cycle();
        cycle();
        chk("single_bubble_one", 64'(bubble_cnt), 64'd1);

        // back-to-back stream
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(8'h10 + i), 64'(i));
            cycle();
        end
        drive(1'b0, '0, '0);
        repeat (2) cycle();

        // backpressure fills the skid, then drains in order
        out_ready = 1'b0;
        drive(1'b1, 8'hA1, 64'hAAAA);
        cycle();
        drive(1'b1, 8'hB2, 64'hBBBB);
        cycle();
        drive(1'b0, '0, '0);
        cycle();
        chk("full_in_ready", 64'(in_ready), 64'h0);
        out_ready = 1'b1;
        repeat (3) cycle();

        // flush a full stage with a same-cycle input
        out_ready = 1'b0;
        drive(1'b1, 8'hC1, 64'hC1C1);
        cycle();
        drive(1'b1, 8'hC2, 64'hC2C2);
        cycle();
        flush = 1'b1;
        drive(1'b1, 8'hCC, 64'hCCCC);
        cycle();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        chk("flush_out_ctrl", 64'(out_ctrl), 64'h0);
        chk("flush_out_valid", 64'(out_valid), 64'h0);
        chk("flush_in_ready", 64'(in_ready), 64'h1);
        out_ready = 1'b1;
        repeat (2) cycle();

        // freeze holds one entry for three cycles
        out_ready = 1'b0;
        drive(1'b1, 8'h77, 64'h7777);
        cycle();
        drive(1'b0, '0, '0);
        out_ready = 1'b1; freeze = 1'b1; bubble_clr = 1'b1;
        cycle();
        bubble_clr = 1'b0;
        bub_before = 0;
        repeat (3) cycle();
        chk("freeze_bubbles", 64'(bubble_cnt), 64'(bub_before + 3));
        freeze = 1'b0;
        cycle();
        cycle();

        // saturation and clear
        bubble_clr = 1'b1;
        cycle();
        bubble_clr = 1'b0;
        repeat (20) cycle();
        chk("bubble_sat", 64'(bubble_cnt), 64'(CNT_MAX));
        bubble_clr = 1'b1;
        cycle();
        bubble_clr = 1'b0;
        chk("bubble_clr", 64'(bubble_cnt), 64'h0);

        // asynchronous reset while streaming
        out_ready = 1'b0;
        drive(1'b1, 8'h31, 64'h3131);
        cycle();
        drive(1'b1, 8'h32, 64'h3232);
        cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'h0);
        chk("async_in_ready", 64'(in_ready), 64'h0);
        chk("async_out_data", out_data, 64'h0);
        sb.delete();
        exp_bub = 0;
        drive(1'b0, '0, '0);
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 8'h44, 64'h4444);
        cycle();
        drive(1'b0, '0, '0);
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
